// File: rtl/reg_file_pkg.sv
// Shared register-file types and default sizing for decode and writeback.
// Used by reg_file_multiport and reg_file_rd_port.
package reg_file_pkg;

    localparam int XLEN_DEF         = 32;
    localparam int NUM_REGS_DEF     = 32;
    localparam int NUM_RD_PORTS_DEF = 2;
    localparam int AW_DEF           = $clog2(NUM_REGS_DEF);

    typedef logic [XLEN_DEF-1:0] xlen_t;
    typedef logic [AW_DEF-1:0]   reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: zero-register mux, write bypass, data/ack flops.
// Bypass of same-cycle writes is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   addr_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] arr_data_i,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0] data_o,
    output logic            ack_o
);

    localparam logic [AW-1:0] ZERO = AW'(ZERO_REG);

    logic [XLEN-1:0] data_d, data_q;
    logic            ack_q;

    always_comb begin
        data_d = arr_data_i;
`ifdef REG_FILE_BYPASS_EN
        if (wr_en_i && (wr_addr_i == addr_i))
            data_d = wr_data_i;
`endif
        if (addr_i == ZERO)
            data_d = '0;
    end

`ifndef REG_FILE_BYPASS_EN
    logic unused_snoop;
    assign unused_snoop = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            ack_q <= valid_i;
            if (valid_i)
                data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign ack_o  = ack_q;

endmodule

// File: rtl/reg_file_multiport.sv
// Multi-read, single-write integer register file with valid/ack ports.
// Optional write-to-read bypass selected by macro REG_FILE_BYPASS_EN.
module reg_file_multiport
    import reg_file_pkg::*;
#(
    parameter  int XLEN         = XLEN_DEF,
    parameter  int NUM_REGS     = NUM_REGS_DEF,
    parameter  int NUM_RD_PORTS = NUM_RD_PORTS_DEF,
    localparam int AW           = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RD_PORTS*AW-1:0]   reg_rd_addr,
    input  logic [NUM_RD_PORTS-1:0]      reg_rd_addr_valid,
    output logic [NUM_RD_PORTS*XLEN-1:0] reg_rd_data,
    output logic [NUM_RD_PORTS-1:0]      reg_rd_data_ack,
    input  logic [AW-1:0]                reg_wr_addr,
    input  logic [XLEN-1:0]              reg_wr_data,
    input  logic                         reg_wr_data_valid,
    output logic                         reg_wr_ack
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic            wr_ack_q;
    logic            wr_en;

    // r0 is never stored; the read ports force it to zero
    assign wr_en = reg_wr_data_valid && (reg_wr_addr != AW'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            if (wr_en)
                regs_q[reg_wr_addr] <= reg_wr_data;
            wr_ack_q <= reg_wr_data_valid;
        end
    end

    assign reg_wr_ack = wr_ack_q;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = reg_rd_addr[p*AW +: AW];

        reg_file_rd_port #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_rd (
            .clk        (clk),
            .reset      (reset),
            .addr_i     (addr),
            .valid_i    (reg_rd_addr_valid[p]),
            .arr_data_i (regs_q[addr]),
            .wr_en_i    (wr_en),
            .wr_addr_i  (reg_wr_addr),
            .wr_data_i  (reg_wr_data),
            .data_o     (reg_rd_data[p*XLEN +: XLEN]),
            .ack_o      (reg_rd_data_ack[p])
        );
    end

endmodule
